// File: rtl/ifetch_queue.sv
// Instruction prefetch queue: owns the fetch PC, keeps one request to imem in flight, buffers words for decode.
// Latency: ack in cycle t is visible to decode in t+1. Backpressure: fetching stalls while the FIFO is full.
module ifetch_queue #(
    parameter int              DEPTH    = 4,
    parameter int              PC_W     = 16,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clock,
    input  logic            resetn,
    input  logic [17:0]     brbus,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [15:0]     imem_rdata,
    output logic [15:0]     inst,
    output logic [PC_W-1:0] inst_pc,
    output logic            inst_valid,
    input  logic            inst_ready
);
    localparam int            AW   = $clog2(DEPTH);
    localparam logic [AW:0]   FULL = (AW+1)'(DEPTH);

    logic [15:0]     dat_q [DEPTH];
    logic [PC_W-1:0] pc_q  [DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]     count_q, count_d;
    logic [PC_W-1:0] fetch_pc_q, fetch_pc_d, req_pc_q, req_pc_d;
    logic            pending_q, pending_d, discard_q, discard_d;

    logic            redirect, ack_vld, push, pop;
    logic [PC_W-1:0] br_target;

    assign redirect  = brbus[17] & brbus[16];
    assign br_target = PC_W'(brbus[15:0]);
    // A stray ack with nothing outstanding (e.g. after a mid-request reset) is ignored.
    assign ack_vld   = imem_ack & pending_q;
    assign push      = ack_vld & ~discard_q & ~redirect;
    assign pop       = inst_valid & inst_ready;

    assign imem_req   = resetn & ~pending_q & (count_q < FULL) & ~redirect;
    assign imem_addr  = fetch_pc_q;
    assign inst       = dat_q[rd_ptr_q];
    assign inst_pc    = pc_q[rd_ptr_q];
    assign inst_valid = (count_q != '0);

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        req_pc_d   = req_pc_q;
        pending_d  = pending_q;
        discard_d  = discard_q;
        wr_ptr_d   = wr_ptr_q + AW'(push);
        rd_ptr_d   = rd_ptr_q + AW'(pop);
        count_d    = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
        if (imem_req) begin
            fetch_pc_d = fetch_pc_q + PC_W'(1);
            req_pc_d   = fetch_pc_q;
            pending_d  = 1'b1;
        end
        if (ack_vld) begin
            pending_d = 1'b0;
            discard_d = 1'b0;
        end
        if (redirect) begin
            fetch_pc_d = br_target;
            count_d    = '0;
            rd_ptr_d   = wr_ptr_q;
            if (pending_q & ~imem_ack) begin
                discard_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            fetch_pc_q <= RESET_PC;
            req_pc_q   <= '0;
            pending_q  <= 1'b0;
            discard_q  <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                dat_q[i] <= '0;
                pc_q[i]  <= '0;
            end
        end else begin
            fetch_pc_q <= fetch_pc_d;
            req_pc_q   <= req_pc_d;
            pending_q  <= pending_d;
            discard_q  <= discard_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            if (push) begin
                dat_q[wr_ptr_q] <= imem_rdata;
                pc_q[wr_ptr_q]  <= req_pc_q;
            end
        end
    end
endmodule
